// File: rtl/instr_sequencer.sv
// Program sequencer: loads 16-bit words a byte at a time, then issues them to
// the core in order with repeat passes, compare-skip and abort support.
module instr_sequencer #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   input  logic          start,
   input  logic          stop,
   input  logic          clear,
   input  logic [3:0]    reps,
   input  logic          cmp_bit,
   output logic [15:0]   instr_out,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic [AW:0]   prog_len,
   output logic          busy,
   output logic          done,
   output logic          load_err
);

   typedef enum logic [1:0] {IDLE, LOAD_HI, RUN} state_t;

   state_t      state, state_next;
   logic [15:0] mem [DEPTH];
   logic [7:0]  low_byte;
   logic [3:0]  rep_cnt;
   logic [AW:0] pc_next;
   logic        skip;
   logic        end_pass;
   logic        full;

   assign full = (prog_len == (AW+1)'(DEPTH));

   // A compare instruction whose result bit is set skips the following word.
   assign skip     = (instr_out[1:0] == 2'b11) && (instr_out[15:13] == 3'b011) && cmp_bit;
   assign pc_next  = {1'b0, pc} + (skip ? (AW+1)'(2) : (AW+1)'(1));
   assign end_pass = (pc_next >= prog_len);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the default assignment first keeps this combinational process
   // from inferring a latch on paths that leave state_next untouched.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (clear)           state_next = IDLE;
            else if (start)      state_next = (prog_len != '0) ? RUN : IDLE;
            else if (byte_valid) state_next = LOAD_HI;
         end
         LOAD_HI: if (byte_valid) state_next = IDLE;
         RUN: begin
            if (stop)                              state_next = IDLE;
            else if (end_pass && rep_cnt == 4'd0)  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == RUN);
      instr_valid = busy;
      instr_out   = busy ? mem[pc] : 16'h0000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= '0;
         prog_len <= '0;
         rep_cnt  <= 4'd0;
         load_err <= 1'b0;
         done     <= 1'b0;
         low_byte <= 8'h00;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear) begin
                  prog_len <= '0;
                  load_err <= 1'b0;
               end else if (start) begin
                  if (prog_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     pc      <= '0;
                     rep_cnt <= reps;
                  end
               end else if (byte_valid) begin
                  low_byte <= byte_in;
               end
            end
            LOAD_HI: begin
               if (byte_valid) begin
                  if (full) load_err <= 1'b1;
                  else      prog_len <= prog_len + (AW+1)'(1);
               end
            end
            RUN: begin
               if (!stop) begin
                  if (end_pass) begin
                     pc <= '0;
                     if (rep_cnt == 4'd0) done    <= 1'b1;
                     else                 rep_cnt <= rep_cnt - 4'd1;
                  end else begin
                     pc <= pc_next[AW-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: program memory has no reset; its contents are only meaningful
   // below prog_len, which reset and clear already zero.
   always_ff @(posedge clk) begin
      if (state == LOAD_HI && byte_valid && !full)
         mem[prog_len[AW-1:0]] <= {byte_in, low_byte};
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs driven and outputs sampled on the
// falling clock edge; expected values are hand-computed constants.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        start;
   logic        stop;
   logic        clear;
   logic [3:0]  reps;
   logic        cmp_bit;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic [2:0]  pc;
   logic [3:0]  prog_len;
   logic        busy;
   logic        done;
   logic        load_err;

   int vectors = 0;
   int errors  = 0;

   instr_sequencer #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .start(start), .stop(stop), .clear(clear), .reps(reps), .cmp_bit(cmp_bit),
      .instr_out(instr_out), .instr_valid(instr_valid), .pc(pc),
      .prog_len(prog_len), .busy(busy), .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_word(input logic [15:0] w);
      @(negedge clk); byte_valid = 1'b1; byte_in = w[7:0];
      @(negedge clk); byte_in = w[15:8];
      @(negedge clk); byte_valid = 1'b0;
   endtask

   // Returns at the falling edge of the first RUN cycle (or the done cycle).
   task automatic do_start(input logic [3:0] r);
      @(negedge clk); start = 1'b1; reps = r;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; start = 1'b0;
      stop = 1'b0; clear = 1'b0; reps = 4'd0; cmp_bit = 1'b0;

      // Reset state, before any clock edge
      #3;
      check("rst_busy", busy, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr_out, 16'h0000);
      check("rst_pc", pc, 0);
      check("rst_len", prog_len, 0);
      check("rst_err", load_err, 0);
      check("rst_done", done, 0);
      @(negedge clk); rst = 1'b0;

      // Two-word load and single pass
      load_word(16'h2101);
      load_word(16'h4005);
      check("t37_len", prog_len, 2);
      do_start(4'd0);
      check("t37_v0", instr_valid, 1);
      check("t37_i0", instr_out, 16'h2101);
      check("t37_pc0", pc, 0);
      check("t37_busy", busy, 1);
      tick();
      check("t37_v1", instr_valid, 1);
      check("t37_i1", instr_out, 16'h4005);
      check("t37_pc1", pc, 1);
      check("t37_done_early", done, 0);
      tick();
      check("t37_done", done, 1);
      check("t37_v_end", instr_valid, 0);
      check("t37_busy_end", busy, 0);
      check("t37_i_end", instr_out, 16'h0000);
      tick();
      check("t37_done_once", done, 0);

      // Compare-skip over word1
      do_clear();
      load_word(16'h6003);
      load_word(16'h1111);
      load_word(16'h2222);
      check("t38_len", prog_len, 3);
      do_start(4'd0);
      cmp_bit = 1'b1;
      check("t38_i0", instr_out, 16'h6003);
      check("t38_pc0", pc, 0);
      tick();
      cmp_bit = 1'b0;
      check("t38_pc2", pc, 2);
      check("t38_i2", instr_out, 16'h2222);
      check("t38_v2", instr_valid, 1);
      tick();
      check("t38_done", done, 1);
      check("t38_v_end", instr_valid, 0);

      // Repeat passes back to back
      do_clear();
      load_word(16'hA001);
      load_word(16'hB002);
      do_start(4'd2);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t39_pc%0d", i), pc, i % 2);
         check($sformatf("t39_i%0d", i), instr_out, (i % 2 == 0) ? 16'hA001 : 16'hB002);
         check($sformatf("t39_v%0d", i), instr_valid, 1);
         check($sformatf("t39_nd%0d", i), done, 0);
         if (i < 5) tick();
      end
      tick();
      check("t39_done", done, 1);
      check("t39_busy", busy, 0);
      tick();
      check("t39_done_once", done, 0);

      // Overflow load, drop of ninth word, clear, empty start
      do_clear();
      for (int i = 0; i < 8; i++) load_word(16'h1000 + 16'(i));
      check("t40_len8", prog_len, 8);
      check("t40_err0", load_err, 0);
      load_word(16'hFFFF);
      check("t40_len_sat", prog_len, 8);
      check("t40_err1", load_err, 1);
      do_start(4'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t40_i%0d", i), instr_out, 16'h1000 + 16'(i));
         tick();
      end
      check("t40_run_done", done, 1);
      check("t40_err_kept", load_err, 1);
      do_clear();
      check("t40_len_clr", prog_len, 0);
      check("t40_err_clr", load_err, 0);
      @(negedge clk); clear = 1'b1; start = 1'b1;
      @(negedge clk); clear = 1'b0; start = 1'b0;
      check("t40_clr_prio", done, 0);
      do_start(4'd0);
      check("t40_empty_done", done, 1);
      check("t40_empty_busy", busy, 0);
      check("t40_empty_valid", instr_valid, 0);
      tick();
      check("t40_empty_once", done, 0);

      // Abort on the second issue cycle
      load_word(16'h0001);
      load_word(16'h0002);
      load_word(16'h0004);
      load_word(16'h0008);
      do_start(4'd0);
      check("t41_i0", instr_out, 16'h0001);
      tick();
      stop = 1'b1;
      check("t41_i1", instr_out, 16'h0002);
      check("t41_v1", instr_valid, 1);
      tick();
      stop = 1'b0;
      check("t41_busy", busy, 0);
      check("t41_valid", instr_valid, 0);
      check("t41_nodone", done, 0);
      tick();
      check("t41_nodone2", done, 0);

      // Asynchronous reset mid-run
      do_start(4'd0);
      tick();
      check("t42_pre_pc", pc, 1);
      #2 rst = 1'b1;
      #1;
      check("t42_busy", busy, 0);
      check("t42_valid", instr_valid, 0);
      check("t42_instr", instr_out, 16'h0000);
      check("t42_pc", pc, 0);
      check("t42_len", prog_len, 0);
      @(negedge clk); rst = 1'b0;

      // Asynchronous reset after a lone low byte
      @(negedge clk); byte_valid = 1'b1; byte_in = 8'h34;
      @(negedge clk); byte_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("t42b_len", prog_len, 0);
      check("t42b_busy", busy, 0);
      @(negedge clk); rst = 1'b0;
      load_word(16'hABCD);
      check("t42b_len1", prog_len, 1);
      do_start(4'd0);
      check("t42b_i0", instr_out, 16'hABCD);
      tick();
      check("t42b_done", done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
